// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: states, ALU controls, opcodes, mux selects.
`timescale 1ns/1ps
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTER = 4'd7,
    S_EXECUTEI = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
    S_JAL      = 4'd11
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] IMM_I      = 2'b00;
  localparam logic [1:0] IMM_S      = 2'b01;
  localparam logic [1:0] IMM_B      = 2'b10;
  localparam logic [1:0] IMM_J      = 2'b11;

  function automatic logic op_legal(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_BRANCH) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse alu_op plus instruction funct fields to the ALU control encoding.
`timescale 1ns/1ps
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type from I-type so addi with imm[10] set is not a sub
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default:     alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I datapath; outputs are registered from the next state.
// Optional macro CTRL_BNE_EN: BEQ state also resolves BNE via funct3[0].
`timescale 1ns/1ps
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter int STATE_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  zero_flag,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic                  reg_write,
  output logic                  mem_write,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [1:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal_op,
  output logic [STATE_W-1:0]    state_o
);

  state_t     state_q, state_d;
  logic       pc_write_q, ir_write_q, reg_write_q, mem_write_q;
  logic       pc_write_d, ir_write_d, reg_write_d, mem_write_d;
  logic [1:0] src_a_q, src_b_q, result_src_q, imm_src_q;
  logic [1:0] src_a_d, src_b_d, result_src_d, imm_src_d;
  logic [1:0] alu_op_d;
  logic [2:0] alu_ctrl_q, alu_ctrl_d;
  logic       branch_taken;

  always_comb begin
    state_d = S_RST;
    case (state_q)
      S_RST:      state_d = S_FETCH;
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_RST;
    endcase
  end

  // Decode the outputs of the state being entered so they come straight from flops.
  always_comb begin
    pc_write_d   = 1'b0;
    ir_write_d   = 1'b0;
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    src_a_d      = SRCA_PC;
    src_b_d      = SRCB_RS2;
    result_src_d = RES_ALUOUT;
    imm_src_d    = IMM_I;
    alu_op_d     = ALUOP_ADD;
    case (state_d)
      S_FETCH: begin
        ir_write_d   = 1'b1;
        pc_write_d   = 1'b1;
        src_b_d      = SRCB_FOUR;
        result_src_d = RES_ALU;
      end
      S_DECODE: begin
        src_a_d   = SRCA_OLDPC;
        src_b_d   = SRCB_IMM;
        imm_src_d = IMM_B;
      end
      S_MEMADR: begin
        src_a_d   = SRCA_RS1;
        src_b_d   = SRCB_IMM;
        imm_src_d = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMWB: begin
        result_src_d = RES_DATA;
        reg_write_d  = 1'b1;
      end
      S_MEMWRITE: mem_write_d = 1'b1;
      S_EXECUTER: begin
        src_a_d  = SRCA_RS1;
        alu_op_d = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        src_a_d  = SRCA_RS1;
        src_b_d  = SRCB_IMM;
        alu_op_d = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write_d = 1'b1;
      S_BEQ: begin
        src_a_d  = SRCA_RS1;
        alu_op_d = ALUOP_SUB;
      end
      S_JAL: begin
        src_a_d    = SRCA_OLDPC;
        src_b_d    = SRCB_FOUR;
        pc_write_d = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op_d),
    .op5         (op[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (alu_ctrl_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RST;
      pc_write_q   <= 1'b0;
      ir_write_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      src_a_q      <= 2'b00;
      src_b_q      <= 2'b00;
      result_src_q <= 2'b00;
      imm_src_q    <= 2'b00;
      alu_ctrl_q   <= ALU_ADD;
    end else begin
      state_q      <= state_d;
      pc_write_q   <= pc_write_d;
      ir_write_q   <= ir_write_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      src_a_q      <= src_a_d;
      src_b_q      <= src_b_d;
      result_src_q <= result_src_d;
      imm_src_q    <= imm_src_d;
      alu_ctrl_q   <= alu_ctrl_d;
    end
  end

`ifdef CTRL_BNE_EN
  assign branch_taken = funct3[0] ? ~zero_flag : zero_flag;
`else
  assign branch_taken = zero_flag;
`endif

  // zero_flag is only valid during the compare cycle itself, so the branch term is combinational.
  assign pc_write    = pc_write_q | ((state_q == S_BEQ) & branch_taken);
  assign ir_write    = ir_write_q;
  assign reg_write   = reg_write_q;
  assign mem_write   = mem_write_q;
  assign alu_src_a   = src_a_q;
  assign alu_src_b   = src_b_q;
  assign result_src  = result_src_q;
  assign imm_src     = imm_src_q;
  assign alu_control = ALU_CTRL_W'(alu_ctrl_q);
  assign illegal_op  = (state_q == S_DECODE) & ~op_legal(op);
  assign state_o     = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class state by state.
`timescale 1ns/1ps
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        zero_flag;
  logic        pc_write, ir_write, reg_write, mem_write, illegal_op;
  logic [1:0]  alu_src_a, alu_src_b, result_src, imm_src;
  logic [2:0]  alu_control;
  logic [3:0]  state_o;
  logic [15:0] obs;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (instr[6:0]),
    .funct3      (instr[14:12]),
    .funct7b5    (instr[30]),
    .zero_flag   (zero_flag),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .mem_write   (mem_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .result_src  (result_src),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .illegal_op  (illegal_op),
    .state_o     (state_o)
  );

  assign obs = {pc_write, ir_write, reg_write, mem_write, alu_src_a, alu_src_b,
                result_src, imm_src, alu_control, illegal_op};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] cv(input logic pc, input logic ir, input logic rw,
                                     input logic mw, input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] rs, input logic [1:0] imm,
                                     input logic [2:0] alu, input logic ill);
    return {pc, ir, rw, mw, a, b, rs, imm, alu, ill};
  endfunction

  task automatic step(input string tag, input logic [3:0] st, input logic [15:0] c);
    @(negedge clk);
    #1;
    chk({tag, ".state"}, 32'(state_o), 32'(st));
    chk({tag, ".ctl"}, 32'(obs), 32'(c));
  endtask

  task automatic fetch_decode(input string tag);
    step({tag, ".fetch"}, 4'd1, cv(1, 1, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 0));
    step({tag, ".decode"}, 4'd2, cv(0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000, 0));
  endtask

  task automatic branch(input string tag, input logic pc_z1, input logic pc_z0);
    @(negedge clk);
    zero_flag = 1'b1;
    #1;
    chk({tag, ".state"}, 32'(state_o), 32'd10);
    chk({tag, ".z1"}, 32'(obs), 32'(cv(pc_z1, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001, 0)));
    zero_flag = 1'b0;
    #1;
    chk({tag, ".z0"}, 32'(obs), 32'(cv(pc_z0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001, 0)));
  endtask

  logic [15:0] aluwb;
  logic        bne_z1, bne_z0;

  initial begin
    aluwb     = cv(0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
`ifdef CTRL_BNE_EN
    bne_z1 = 1'b0;
    bne_z0 = 1'b1;
`else
    bne_z1 = 1'b1;
    bne_z0 = 1'b0;
`endif
    rst_n     = 1'b0;
    zero_flag = 1'b0;
    instr     = 32'h402081B3;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.state", 32'(state_o), 32'd0);
    chk("rst.ctl", 32'(obs), 32'd0);
    rst_n = 1'b1;

    // sub x3,x1,x2
    fetch_decode("sub");
    step("sub.exec", 4'd7, cv(0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001, 0));
    step("sub.wb", 4'd9, aluwb);
    instr = 32'h0020F1B3;

    // and x3,x1,x2
    fetch_decode("and");
    step("and.exec", 4'd7, cv(0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b010, 0));
    step("and.wb", 4'd9, aluwb);
    instr = 32'h0020A193;

    // slti x3,x1,2
    fetch_decode("slti");
    step("slti.exec", 4'd8, cv(0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b101, 0));
    step("slti.wb", 4'd9, aluwb);
    instr = 32'hC0008193;

    // addi x3,x1,-1024: bit 30 set but I-type must stay add
    fetch_decode("addi");
    step("addi.exec", 4'd8, cv(0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000, 0));
    step("addi.wb", 4'd9, aluwb);
    instr = 32'h0000A183;

    // lw x3,0(x1): funct3 010 must not leak into MEMADR as slt
    fetch_decode("lw");
    step("lw.memadr", 4'd3, cv(0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000, 0));
    step("lw.memread", 4'd4, 16'h0000);
    step("lw.memwb", 4'd5, cv(0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 0));
    instr = 32'h0030A023;

    // sw x3,0(x1)
    fetch_decode("sw");
    step("sw.memadr", 4'd3, cv(0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b01, 3'b000, 0));
    step("sw.memwrite", 4'd6, cv(0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    instr = 32'h00208463;

    fetch_decode("beq");
    branch("beq", 1'b1, 1'b0);
    instr = 32'h00209463;

    fetch_decode("bne");
    branch("bne", bne_z1, bne_z0);
    instr = 32'h008000EF;

    // jal x1,8
    fetch_decode("jal");
    step("jal.jal", 4'd11, cv(1, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000, 0));
    step("jal.wb", 4'd9, aluwb);
    instr = 32'h0000007F;

    step("ill.fetch", 4'd1, cv(1, 1, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 0));
    step("ill.decode", 4'd2, cv(0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000, 1));
    step("ill.next", 4'd1, cv(1, 1, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 0));
    instr = 32'h0030A023;

    // store interrupted by reset in MEMWRITE
    step("sw2.decode", 4'd2, cv(0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000, 0));
    step("sw2.memadr", 4'd3, cv(0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b01, 3'b000, 0));
    step("sw2.memwrite", 4'd6, cv(0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    rst_n = 1'b0;
    #1;
    chk("midrst.memwrite", 32'(mem_write), 32'd0);
    chk("midrst.state", 32'(state_o), 32'd0);
    chk("midrst.ctl", 32'(obs), 32'd0);
    @(negedge clk);
    #1;
    chk("midrst.hold", 32'(obs), 32'd0);
    rst_n = 1'b1;
    instr = 32'h402081B3;
    fetch_decode("restart");
    step("restart.exec", 4'd7, cv(0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
